// File: rtl/tone_synth_if.sv
// Playback/recorder bus: note buffer supplies playback notes, recorder consumes note strobes.
interface tone_synth_if;
    logic       pb_mode;
    logic       pb_valid;
    logic [5:0] pb_note;
    logic [5:0] note_code;
    logic       note_valid;

    modport master (
        output pb_mode, pb_valid, pb_note,
        input  note_code, note_valid
    );

    modport slave (
        input  pb_mode, pb_valid, pb_note,
        output note_code, note_valid
    );
endinterface

// File: rtl/tone_synth.sv
// Square-wave tone generator: live switch/octave selection or buffer playback,
// driving a 50%-duty speaker output from per-note half-period counters.
module tone_synth #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int OCT_MAX   = 4,
    parameter int OCT_RESET = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] note_switches,
    input  logic       inc_octave,
    input  logic       dec_octave,
    tone_synth_if.slave bus,
    output logic       audio_out,
    output logic [2:0] octave
);
    // Longest half period (C2, ~65 Hz) stays below CLK_HZ/100 cycles.
    localparam int CNT_W = $clog2(CLK_HZ / 100);
    localparam logic [5:0] REST_CODE = 6'b000111;

    typedef enum logic {IDLE, RUN} state_e;

    logic [6:0]       sw_s1_q, sw_s2_q;
    logic             inc_s1_q, inc_s2_q, inc_prev_q;
    logic             dec_s1_q, dec_s2_q, dec_prev_q;
    logic [2:0]       oct_q, oct_d;
    logic [5:0]       sel_q, sel_d;
    logic             nv_q, nv_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, reload;
    logic             aud_q, aud_d;
    logic             inc_edge, dec_edge, sel_rest;

    function automatic logic [2:0] lowest_set(input logic [6:0] v);
        lowest_set = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

    function automatic logic [CNT_W-1:0] half_of(input logic [5:0] s);
        logic [CNT_W-1:0] b;
        case (s[2:0])
            3'd0:    b = CNT_W'(764452);
            3'd1:    b = CNT_W'(681048);
            3'd2:    b = CNT_W'(606744);
            3'd3:    b = CNT_W'(572692);
            3'd4:    b = CNT_W'(510204);
            3'd5:    b = CNT_W'(454544);
            3'd6:    b = CNT_W'(404956);
            default: b = '0;
        endcase
        half_of = b >> s[5:3];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            inc_s1_q   <= 1'b0;
            inc_s2_q   <= 1'b0;
            inc_prev_q <= 1'b0;
            dec_s1_q   <= 1'b0;
            dec_s2_q   <= 1'b0;
            dec_prev_q <= 1'b0;
            oct_q      <= 3'(OCT_RESET);
            sel_q      <= REST_CODE;
            nv_q       <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            aud_q      <= 1'b0;
        end else begin
            sw_s1_q    <= note_switches;
            sw_s2_q    <= sw_s1_q;
            inc_s1_q   <= inc_octave;
            inc_s2_q   <= inc_s1_q;
            inc_prev_q <= inc_s2_q;
            dec_s1_q   <= dec_octave;
            dec_s2_q   <= dec_s1_q;
            dec_prev_q <= dec_s2_q;
            oct_q      <= oct_d;
            sel_q      <= sel_d;
            nv_q       <= nv_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            aud_q      <= aud_d;
        end
    end

    always_comb begin
        inc_edge = inc_s2_q & ~inc_prev_q;
        dec_edge = dec_s2_q & ~dec_prev_q;
        oct_d    = oct_q;
        if (!bus.pb_mode && (inc_edge != dec_edge)) begin
            if (inc_edge && (oct_q != 3'(OCT_MAX)))
                oct_d = oct_q + 3'd1;
            else if (dec_edge && (oct_q != 3'd0))
                oct_d = oct_q - 3'd1;
        end
    end

    // Playback octaves above OCT_MAX are clamped rather than wrapped.
    always_comb begin
        sel_d = REST_CODE;
        if (!bus.pb_mode)
            sel_d = {oct_q, lowest_set(sw_s2_q)};
        else if (bus.pb_valid)
            sel_d = {(bus.pb_note[5:3] > 3'(OCT_MAX)) ? 3'(OCT_MAX) : bus.pb_note[5:3],
                     bus.pb_note[2:0]};
        nv_d = !bus.pb_mode && (sel_d != sel_q) && (sel_d[2:0] != 3'd7);
    end

    always_comb begin
        sel_rest = (sel_q[2:0] == 3'd7);
        reload   = half_of(sel_q) - CNT_W'(1);
        state_d  = state_q;
        cnt_d    = cnt_q;
        aud_d    = aud_q;
        case (state_q)
            IDLE: begin
                aud_d = 1'b0;
                cnt_d = '0;
                if (!sel_rest) begin
                    cnt_d   = reload;
                    aud_d   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Retuning only takes effect at the reload, so a half period is never cut short.
                if (sel_rest) begin
                    aud_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    aud_d = ~aud_q;
                    cnt_d = reload;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                aud_d   = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign audio_out      = aud_q;
    assign octave         = oct_q;
    assign bus.note_code  = sel_q;
    assign bus.note_valid = nv_q;
endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth: a scoreboard queue holds expected note_valid codes,
// a monitor pops and compares on every strobe; timing checks run inline.
module tb_tone_synth;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] sw;
    logic       inc, dec;
    logic       audio;
    logic [2:0] octave;
    int         checks = 0;
    int         errors = 0;
    logic [5:0] expq[$];
    int         n;

    tone_synth_if tif ();

    tone_synth dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .note_switches (sw),
        .inc_octave    (inc),
        .dec_octave    (dec),
        .bus           (tif),
        .audio_out     (audio),
        .octave        (octave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse(input logic i, input logic d);
        inc = i;
        dec = d;
        tick(3);
        inc = 1'b0;
        dec = 1'b0;
        tick(3);
    endtask

    // Counts cycles while audio holds lvl; optionally swaps pb_note partway through.
    task automatic measure(input logic lvl, output int cnt, input int retune_at,
                           input logic [5:0] new_note);
        cnt = 0;
        while (audio === lvl && cnt < 60000) begin
            @(negedge clk);
            cnt++;
            if (cnt == retune_at) tif.pb_note = new_note;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && tif.note_valid === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected note_valid: code %0d, no strobe required", tif.note_code);
            end else begin
                chk("note_valid code", {26'd0, tif.note_code}, {26'd0, expq.pop_front()});
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        sw = '0;
        inc = 1'b0;
        dec = 1'b0;
        tif.pb_mode = 1'b0;
        tif.pb_valid = 1'b0;
        tif.pb_note = '0;
        tick(2);
        chk("reset audio", audio, 0);
        chk("reset code", tif.note_code, 6'o07);
        chk("reset note_valid", tif.note_valid, 0);
        chk("reset octave", octave, 2);
        rst_n = 1'b1;
        tick(1);

        // A alone at octave 2
        sw = 7'b0100000;
        expq.push_back(6'o25);
        tick(2);
        chk("A latency rest", tif.note_code[2:0], 7);
        tick(1);
        chk("A code", tif.note_code, 6'o25);
        chk("A audio before rise", audio, 0);
        tick(1);
        chk("A audio rise", audio, 1);
        tick(1000);
        chk("A audio held", audio, 1);
        sw = '0;
        tick(3);
        chk("release code rest", tif.note_code[2:0], 7);
        chk("release audio pending", audio, 1);
        tick(1);
        chk("release audio low", audio, 0);
        tick(5);
        chk("idle audio", audio, 0);

        // C and E together, then release C
        sw = 7'b0000101;
        expq.push_back(6'o20);
        tick(4);
        chk("C code", tif.note_code, 6'o20);
        chk("C audio", audio, 1);
        tick(100);
        sw = 7'b0000100;
        expq.push_back(6'o22);
        tick(3);
        chk("E code", tif.note_code, 6'o22);
        n = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (audio !== 1'b1) n++;
        end
        chk("C half period not cut", n, 0);
        sw = '0;
        tick(5);
        chk("CE release audio", audio, 0);

        // Octave saturation and simultaneous edges
        repeat (6) pulse(1'b1, 1'b0);
        chk("octave sat max", octave, 4);
        repeat (6) pulse(1'b0, 1'b1);
        chk("octave sat min", octave, 0);
        pulse(1'b1, 1'b0);
        chk("octave inc", octave, 1);
        pulse(1'b1, 1'b1);
        chk("octave inc+dec", octave, 1);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        chk("octave 3", octave, 3);

        // B held, octave change re-strobes
        sw = 7'b1000000;
        expq.push_back(6'o36);
        tick(4);
        chk("B3 audio", audio, 1);
        expq.push_back(6'o46);
        pulse(1'b1, 1'b0);
        chk("B octave 4", octave, 4);
        chk("B4 code", tif.note_code, 6'o46);
        sw = '0;
        tick(5);
        chk("B release audio", audio, 0);

        // Playback: clamped F, then retune to B mid half period; live inputs ignored
        sw = 7'b0000001;
        dec = 1'b1;
        tif.pb_mode = 1'b1;
        tif.pb_valid = 1'b1;
        tif.pb_note = 6'o73;
        tick(1);
        chk("pb F code", tif.note_code, 6'o43);
        chk("pb audio before rise", audio, 0);
        tick(1);
        chk("pb audio rise", audio, 1);
        measure(1'b1, n, 100, 6'o46);
        chk("pb F half period", n, 35793);
        measure(1'b0, n, 0, 6'o46);
        chk("pb B4 half period", n, 25309);
        chk("pb B code", tif.note_code, 6'o46);
        chk("pb octave ignored", octave, 4);
        tif.pb_valid = 1'b0;
        sw = '0;
        tick(1);
        chk("pb rest code", tif.note_code[2:0], 7);
        tick(1);
        chk("pb rest audio", audio, 0);
        tif.pb_mode = 1'b0;
        dec = 1'b0;
        tick(5);
        chk("live return octave", octave, 4);

        // Asynchronous reset mid-tone
        sw = 7'b0010000;
        expq.push_back(6'o44);
        tick(4);
        chk("G audio", audio, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sw = '0;
        #1;
        chk("async rst audio", audio, 0);
        chk("async rst octave", octave, 2);
        chk("async rst code", tif.note_code, 6'o07);
        @(negedge clk);
        rst_n = 1'b1;
        tick(10);
        chk("post rst idle audio", audio, 0);
        chk("post rst idle code", tif.note_code[2:0], 7);
        sw = 7'b0000010;
        expq.push_back(6'o21);
        tick(4);
        chk("D code", tif.note_code, 6'o21);
        chk("D audio", audio, 1);
        sw = '0;
        tick(5);
        chk("scoreboard drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tone_synth.md
# tone_synth

Square-wave tone generator sitting directly downstream of the debounced input stage and alongside the recording note buffer. It resolves the seven debounced note switches plus an internal octave register into one note code. In live mode it emits a one-cycle strobe and the 6-bit code so the recorder can store it. In playback mode it sounds notes supplied by the buffer instead. It drives a 50%-duty square wave to the speaker pin using per-note half-period counters.

## Interface
- CLK_HZ, 100_000_000: system clock frequency; the half-period table below is valid only for this value.
- OCT_MAX, 4: highest octave index; octave indices 0..OCT_MAX map to musical octaves 2..6.
- OCT_RESET, 2: octave index loaded at reset.

Ports:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- note_switches  in  7  debounced levels from the slow clock domain; bit0 = C … bit6 = B.
- inc_octave  in  1  debounced level from the slow domain.
- dec_octave  in  1  debounced level from the slow domain.
- pb_mode  in  1  clk-domain level; 1 selects playback source.
- pb_valid  in  1  clk-domain; pb_note is meaningful while high.
- pb_note  in  6  {octave[2:0], note[2:0]} from the note buffer.
- audio_out  out  1  square wave to the speaker.
- note_code  out  6  {octave, note} currently selected; note 7 = rest.
- note_valid  out  1  one-cycle strobe to the recorder's add input.
- octave  out  3  current live octave index.

## Operation
- Synchronization:
  - note_switches, inc_octave and dec_octave each pass through a 2-FF synchronizer.
  - pb_* inputs are already in the clk domain and are used unsynchronized.
- Octave register:
  - Rising-edge detect on the synchronized inc/dec levels. The previous-level registers reset to 0.
  - An inc edge increments, saturating at OCT_MAX. A dec edge decrements, saturating at 0.
  - inc and dec edges in the same cycle: no change.
  - Edges are ignored while pb_mode = 1.
- Live selection (pb_mode = 0):
  - Priority encoder picks the lowest set switch bit as the note, 0..6. No bits set gives note 7 (rest).
  - The selection register is loaded from {octave, note} every cycle.
- Playback selection (pb_mode = 1):
  - pb_valid = 1: selection = pb_note, with the octave field clamped to OCT_MAX and note 7 meaning rest.
  - pb_valid = 0: selection = rest.
- note_valid:
  - Pulses high for exactly one cycle when the selection register changes to a non-rest code while pb_mode = 0.
  - This includes an octave change while a key is held.
  - The pulse occurs in the same cycle the new code first appears on note_code.
  - It never pulses in playback mode or on a change to rest.
- Half-period HALF = BASE[note] >> octave, with BASE (20-bit, octave 2):
  - C 764452
  - D 681048
  - E 606744
  - F 572692
  - G 510204
  - A 454544
  - B 404956
- Generator states: IDLE and RUN.
  - IDLE: audio_out = 0 and the counter holds 0. A non-rest selection loads the counter with HALF-1, sets audio_out = 1 and enters RUN.
  - RUN: the counter decrements each cycle. At 0, audio_out toggles and the counter reloads with HALF-1 of the current selection, so retuning is glitch-free at half-period boundaries.
  - Selection becomes rest while in RUN: audio_out = 0, counter = 0, go to IDLE on the next edge. A rest is never deferred.
  - Note-to-note change while in RUN: the current half-period completes, then the new HALF applies from the reload.
  - pb_mode toggling: handled as an ordinary selection change under the rules above.

## Timing
- Reset (asynchronous, immediate): audio_out = 0, note_code = 6'b000111, note_valid = 0, octave = OCT_RESET, state IDLE, counter 0, synchronizers 0.
- Live latency: a switch change present before edge 0 reaches s1 at edge 0 and s2 at edge 1. The selection register and note_valid update at edge 2. From rest, audio_out rises at edge 3.
- Playback latency: a pb_note/pb_valid change before edge 0 updates note_code at edge 0; audio_out responds at edge 1.
- Each audio_out half period lasts exactly HALF clk cycles.
  - Example: A4 (octave index 2) gives HALF = 113636, a period of 227272 cycles ≈ 440.0 Hz.
- Octave latency: an inc/dec level rise before edge 0 updates octave at edge 2.

## Test plan
- Reset, then press SW_A (bit5) alone → note_valid pulses once and note_code = {3'd2, 3'd5}. audio_out goes high, then toggles every 113636 cycles.
- Press C and E together → note 0 is selected (C) with HALF = 191113. Release C while E is still held → a second note_valid pulses with code {2, 2}. The new half period of 151686 cycles starts only after the current C half period finishes.
- Apply 6 inc_octave edges → octave saturates at 4. Apply 6 dec edges → octave reaches 0. Apply inc and dec together → octave is unchanged. Holding B at octave 4 gives half period 25309 cycles.
- Release all switches mid-half-period → audio_out = 0 on the next edge, state is IDLE, and no note_valid pulse occurs.
- pb_mode = 1, pb_valid = 1, pb_note = {3'd7, 3'd3} → octave clamped to 4 and F plays with HALF = 35793. Switches and octave edges are ignored, and note_valid stays 0.
- Assert rst_n low mid-tone, asynchronously → audio_out = 0 and octave = 2 immediately, before the next clk edge. After release, the block stays idle until a switch is pressed.
